// File: rtl/framebuffer_memory_responder_pkg.sv
// Shared AXI constants, responder state encoding and the beat-size helper
// used by the framebuffer memory responder.
package framebuffer_memory_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_WR_RESP = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_DATA = 3'd5
   } state_t;

   // AXI size code for a beat of the given byte count (power of two, up to 128).
   function automatic logic [2:0] log2_bytes(input int bytes);
      logic [2:0] code;
      code = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if ((32'sd1 <<< i) == bytes) begin
            code = 3'(i);
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/framebuffer_memory_responder_burst_length_calc.sv
// Length of the next burst: the remaining beats, clipped so the burst ends at
// the next MAX_BURST_BEATS-beat aligned boundary.
module burst_length_calc #(
   parameter int ADDR_WIDTH      = 32,
   parameter int LOG2_BYTES      = 3,
   parameter int MAX_BURST_BEATS = 16
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [ADDR_WIDTH-1:0] remaining,
   output logic [8:0]            burst_len
);

   localparam logic [ADDR_WIDTH-1:0] IDX_MASK  = ADDR_WIDTH'(MAX_BURST_BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] MAX_BEATS = ADDR_WIDTH'(MAX_BURST_BEATS);

   logic [ADDR_WIDTH-1:0] idx_s;
   logic [ADDR_WIDTH-1:0] room_s;

   // Beats left before the boundary versus beats left in the command.
   always_comb begin
      idx_s  = (addr >> LOG2_BYTES) & IDX_MASK;
      room_s = MAX_BEATS - idx_s;
      if (remaining < room_s) begin
         burst_len = remaining[8:0];
      end else begin
         burst_len = room_s[8:0];
      end
   end

endmodule

// File: rtl/framebuffer_memory_responder.sv
// Memory-side responder: executes framebuffer address commands as AXI4 INCR
// bursts, draining the write pixel stream or returning read data as a stream.
module framebuffer_memory_responder
   import framebuffer_memory_pkg::*;
#(
   parameter int NUMBER_OF_PIXELS_PER_BEAT = 2,
   parameter int NUMBER_OF_SUB_PIXELS      = 4,
   parameter int SUB_PIXEL_WIDTH           = 8,
   parameter int ADDR_WIDTH                = 32,
   parameter int MAX_BURST_BEATS           = 16,
   localparam int STREAM_WIDTH = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
   localparam int STRB_WIDTH   = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
   localparam int BYTES        = STREAM_WIDTH / 8
) (
   input  logic                    aclk,
   input  logic                    resetn,
   input  logic                    s_avalid,
   output logic                    s_aready,
   input  logic [ADDR_WIDTH-1:0]   s_aaddr,
   input  logic [ADDR_WIDTH-1:0]   s_abeats,
   input  logic                    s_arnw,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic [STREAM_WIDTH-1:0] s_axis_tdata,
   input  logic [STRB_WIDTH-1:0]   s_axis_tstrb,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [STREAM_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [STREAM_WIDTH-1:0] m_axi_wdata,
   output logic [BYTES-1:0]        m_axi_wstrb,
   output logic                    m_axi_wlast,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   input  logic [STREAM_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   output logic                    respError
);

   localparam int         BYTES_PER_SUB = SUB_PIXEL_WIDTH / 8;
   localparam logic [2:0] AXI_SIZE      = log2_bytes(BYTES);
   localparam int         LOG2_BYTES    = int'(AXI_SIZE);

   state_t                state_r;
   state_t                state_next_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [ADDR_WIDTH-1:0] remaining_r;
   logic [8:0]            beat_cnt_r;
   logic [8:0]            burst_len_s;
   logic [ADDR_WIDTH-1:0] burst_len_ext_s;
   logic [ADDR_WIDTH-1:0] burst_bytes_s;
   logic                  last_beat_s;
   logic                  final_burst_s;
   logic                  w_fire_s;
   logic                  b_fire_s;
   logic                  r_fire_s;
   logic                  aw_fire_s;
   logic                  ar_fire_s;
   logic                  resp_error_r;
   logic                  unused_s;

   burst_length_calc #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .LOG2_BYTES      (LOG2_BYTES),
      .MAX_BURST_BEATS (MAX_BURST_BEATS)
   ) u_burst_length_calc (
      .addr      (addr_r),
      .remaining (remaining_r),
      .burst_len (burst_len_s)
   );

   assign burst_len_ext_s = ADDR_WIDTH'(burst_len_s);
   assign burst_bytes_s   = burst_len_ext_s << LOG2_BYTES;
   assign last_beat_s     = (beat_cnt_r == (burst_len_s - 9'd1));
   assign final_burst_s   = (remaining_r == burst_len_ext_s);

   assign aw_fire_s = m_axi_awvalid & m_axi_awready;
   assign ar_fire_s = m_axi_arvalid & m_axi_arready;
   assign w_fire_s  = m_axi_wvalid & m_axi_wready;
   assign b_fire_s  = m_axi_bvalid & m_axi_bready;
   assign r_fire_s  = m_axi_rvalid & m_axi_rready;

   // Burst fields come from registers only, so they are stable while a valid waits.
   assign m_axi_awaddr  = addr_r;
   assign m_axi_awlen   = 8'(burst_len_s - 9'd1);
   assign m_axi_awsize  = AXI_SIZE;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_araddr  = addr_r;
   assign m_axi_arlen   = 8'(burst_len_s - 9'd1);
   assign m_axi_arsize  = AXI_SIZE;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_wdata   = s_axis_tdata;
   assign m_axis_tdata  = m_axi_rdata;
   assign respError     = resp_error_r;

   // rlast and the write-stream tlast carry no information here.
   assign unused_s = s_axis_tlast ^ m_axi_rlast;

   // Byte strobes: each sub-pixel strobe covers all bytes of that sub-pixel.
   always_comb begin
      m_axi_wstrb = {BYTES{1'b0}};
      for (int i = 0; i < STRB_WIDTH; i++) begin
         m_axi_wstrb[i*BYTES_PER_SUB +: BYTES_PER_SUB] = {BYTES_PER_SUB{s_axis_tstrb[i]}};
      end
   end

   // Channel controls decoded from the state register.
   always_comb begin
      s_aready      = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      s_axis_tready = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      case (state_r)
         ST_IDLE:    s_aready = resetn;
         ST_WR_ADDR: m_axi_awvalid = 1'b1;
         ST_WR_DATA: begin
            m_axi_wvalid  = s_axis_tvalid;
            s_axis_tready = m_axi_wready;
            m_axi_wlast   = last_beat_s;
         end
         ST_WR_RESP: m_axi_bready = 1'b1;
         ST_RD_ADDR: m_axi_arvalid = 1'b1;
         ST_RD_DATA: begin
            m_axis_tvalid = m_axi_rvalid;
            m_axi_rready  = m_axis_tready;
            m_axis_tlast  = last_beat_s & final_burst_s;
         end
         default:    s_aready = 1'b0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (s_avalid && (s_abeats != {ADDR_WIDTH{1'b0}})) begin
               state_next_s = s_arnw ? ST_WR_ADDR : ST_RD_ADDR;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WR_ADDR: state_next_s = aw_fire_s ? ST_WR_DATA : ST_WR_ADDR;
         ST_WR_DATA: state_next_s = (w_fire_s && last_beat_s) ? ST_WR_RESP : ST_WR_DATA;
         ST_WR_RESP: begin
            if (b_fire_s) begin
               state_next_s = final_burst_s ? ST_IDLE : ST_WR_ADDR;
            end else begin
               state_next_s = ST_WR_RESP;
            end
         end
         ST_RD_ADDR: state_next_s = ar_fire_s ? ST_RD_DATA : ST_RD_ADDR;
         ST_RD_DATA: begin
            if (r_fire_s && last_beat_s) begin
               state_next_s = final_burst_s ? ST_IDLE : ST_RD_ADDR;
            end else begin
               state_next_s = ST_RD_DATA;
            end
         end
         default:    state_next_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Command capture, beat counting and per-burst address/remaining advance.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         addr_r      <= {ADDR_WIDTH{1'b0}};
         remaining_r <= {ADDR_WIDTH{1'b0}};
         beat_cnt_r  <= 9'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               beat_cnt_r <= 9'd0;
               if (s_avalid) begin
                  addr_r      <= s_aaddr;
                  remaining_r <= s_abeats;
               end
            end
            ST_WR_DATA: begin
               if (w_fire_s) begin
                  beat_cnt_r <= last_beat_s ? 9'd0 : (beat_cnt_r + 9'd1);
               end
            end
            ST_WR_RESP: begin
               if (b_fire_s) begin
                  addr_r      <= addr_r + burst_bytes_s;
                  remaining_r <= remaining_r - burst_len_ext_s;
               end
            end
            ST_RD_DATA: begin
               if (r_fire_s) begin
                  if (last_beat_s) begin
                     beat_cnt_r  <= 9'd0;
                     addr_r      <= addr_r + burst_bytes_s;
                     remaining_r <= remaining_r - burst_len_ext_s;
                  end else begin
                     beat_cnt_r <= beat_cnt_r + 9'd1;
                  end
               end
            end
            default: beat_cnt_r <= beat_cnt_r;
         endcase
      end
   end

   // Sticky bus error flag; errors never abort the running command.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         resp_error_r <= 1'b0;
      end else if ((b_fire_s && (m_axi_bresp != AXI_RESP_OKAY)) ||
                   (r_fire_s && (m_axi_rresp != AXI_RESP_OKAY))) begin
         resp_error_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_framebuffer_memory_responder.sv
// Scoreboard bench: a randomly stalling AXI slave, a write-stream source and a
// read-stream sink; expected bursts and beats are queued when commands are issued.
module tb_framebuffer_memory_responder;

   logic aclk   = 1'b0;
   logic resetn = 1'b0;
   always #5 aclk = ~aclk;

   // Main instance, default parameters (64-bit beats, 8 bytes).
   logic        s_avalid = 1'b0, s_aready, s_arnw = 1'b0;
   logic [31:0] s_aaddr = 32'd0, s_abeats = 32'd0;
   logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
   logic [63:0] s_axis_tdata = 64'd0;
   logic [7:0]  s_axis_tstrb = 8'd0;
   logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
   logic [63:0] m_axis_tdata;
   logic        awvalid, awready = 1'b0;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready = 1'b0, wlast;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        bvalid = 1'b0, bready;
   logic [1:0]  bresp = 2'b00;
   logic        arvalid, arready = 1'b0;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid = 1'b0, rready, rlast = 1'b0;
   logic [63:0] rdata = 64'd0;
   logic [1:0]  rresp = 2'b00;
   logic        resp_error;

   framebuffer_memory_responder u_dut (
      .aclk(aclk), .resetn(resetn),
      .s_avalid(s_avalid), .s_aready(s_aready), .s_aaddr(s_aaddr), .s_abeats(s_abeats), .s_arnw(s_arnw),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tdata(m_axis_tdata),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
      .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
      .m_axi_arsize(arsize), .m_axi_arburst(arburst),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .respError(resp_error)
   );

   // Second instance with 16-bit sub-pixels for the strobe replication case.
   logic         w16_avalid = 1'b0, w16_aready;
   logic         w16_tready, w16_m_tvalid, w16_m_tlast;
   logic [127:0] w16_m_tdata, w16_wdata;
   logic         w16_awvalid, w16_wvalid, w16_wlast, w16_bready, w16_arvalid, w16_rready, w16_err;
   logic [31:0]  w16_awaddr, w16_araddr;
   logic [7:0]   w16_awlen, w16_arlen;
   logic [2:0]   w16_awsize, w16_arsize;
   logic [1:0]   w16_awburst, w16_arburst;
   logic [15:0]  w16_wstrb;

   framebuffer_memory_responder #(.SUB_PIXEL_WIDTH(16)) u_dut16 (
      .aclk(aclk), .resetn(resetn),
      .s_avalid(w16_avalid), .s_aready(w16_aready), .s_aaddr(32'd0), .s_abeats(32'd1), .s_arnw(1'b1),
      .s_axis_tvalid(1'b1), .s_axis_tready(w16_tready), .s_axis_tlast(1'b1),
      .s_axis_tdata(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210), .s_axis_tstrb(8'b0000_0101),
      .m_axis_tvalid(w16_m_tvalid), .m_axis_tready(1'b1), .m_axis_tlast(w16_m_tlast), .m_axis_tdata(w16_m_tdata),
      .m_axi_awvalid(w16_awvalid), .m_axi_awready(1'b1), .m_axi_awaddr(w16_awaddr), .m_axi_awlen(w16_awlen),
      .m_axi_awsize(w16_awsize), .m_axi_awburst(w16_awburst),
      .m_axi_wvalid(w16_wvalid), .m_axi_wready(1'b1), .m_axi_wdata(w16_wdata), .m_axi_wstrb(w16_wstrb),
      .m_axi_wlast(w16_wlast),
      .m_axi_bvalid(1'b1), .m_axi_bready(w16_bready), .m_axi_bresp(2'b00),
      .m_axi_arvalid(w16_arvalid), .m_axi_arready(1'b1), .m_axi_araddr(w16_araddr), .m_axi_arlen(w16_arlen),
      .m_axi_arsize(w16_arsize), .m_axi_arburst(w16_arburst),
      .m_axi_rvalid(1'b0), .m_axi_rready(w16_rready), .m_axi_rdata(128'd0), .m_axi_rresp(2'b00),
      .m_axi_rlast(1'b0),
      .respError(w16_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference memory contents returned by the slave on reads.
   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hA5A5_0F0F, ~a};
   endfunction

   logic [44:0] exp_aw_q[$];
   logic [44:0] exp_ar_q[$];
   logic [72:0] exp_w_q[$];
   logic [64:0] exp_m_q[$];
   logic [71:0] src_q[$];
   logic [39:0] rd_q[$];
   int aw_cnt = 0, ar_cnt = 0, b_cnt = 0, m_cnt = 0, b_pend = 0, r_beat = 0;
   int err_burst = -1, stall_at = -1, stall_cnt = 0;

   // Slave, stream source and sink: sample on the falling edge, drive after the rising edge.
   always begin
      logic aw_f, ar_f, w_f, b_f, r_f, s_f, m_f, w_last;
      logic aw_hold = 1'b0, ar_hold = 1'b0;
      logic [39:0] aw_held, ar_held;
      logic [44:0] e45;
      logic [72:0] e73;
      logic [64:0] e65;
      @(negedge aclk);
      aw_f = awvalid & awready;  ar_f = arvalid & arready;
      w_f  = wvalid & wready;    b_f  = bvalid & bready;
      r_f  = rvalid & rready;    s_f  = s_axis_tvalid & s_axis_tready;
      m_f  = m_axis_tvalid & m_axis_tready;
      w_last = wlast;
      if (aw_hold) check_eq("aw_hold", {awvalid, awaddr, awlen}, {1'b1, aw_held});
      if (ar_hold) check_eq("ar_hold", {arvalid, araddr, arlen}, {1'b1, ar_held});
      aw_hold = awvalid & ~awready;  aw_held = {awaddr, awlen};
      ar_hold = arvalid & ~arready;  ar_held = {araddr, arlen};
      if (aw_f) begin
         if (exp_aw_q.size() == 0) check_eq("aw_unexpected", 1'b1, 1'b0);
         else begin e45 = exp_aw_q.pop_front(); check_eq("aw", {awaddr, awlen, awsize, awburst}, e45); end
      end
      if (ar_f) begin
         if (exp_ar_q.size() == 0) check_eq("ar_unexpected", 1'b1, 1'b0);
         else begin e45 = exp_ar_q.pop_front(); check_eq("ar", {araddr, arlen, arsize, arburst}, e45); end
      end
      if (w_f) begin
         if (exp_w_q.size() == 0) check_eq("w_unexpected", 1'b1, 1'b0);
         else begin e73 = exp_w_q.pop_front(); check_eq("w_beat", {wdata, wstrb, wlast}, e73); end
      end
      if (m_f) begin
         if (exp_m_q.size() == 0) check_eq("m_unexpected", 1'b1, 1'b0);
         else begin e65 = exp_m_q.pop_front(); check_eq("m_beat", {m_axis_tdata, m_axis_tlast}, e65); end
      end
      if (stall_cnt > 0) check_eq("rready_stall", rready, 1'b0);
      @(posedge aclk);
      #1;
      if (aw_f) aw_cnt++;
      if (ar_f) begin ar_cnt++; rd_q.push_back({araddr, arlen}); end
      if (w_f && w_last) b_pend++;
      if (b_f) begin b_pend--; b_cnt++; end
      if (r_f && rd_q.size() > 0) begin
         if (r_beat == int'(rd_q[0][7:0])) begin r_beat = 0; void'(rd_q.pop_front()); end
         else r_beat++;
      end
      if (s_f && src_q.size() > 0) void'(src_q.pop_front());
      if (m_f) m_cnt++;
      if (stall_cnt > 0) stall_cnt--;
      else if (m_f && m_cnt == stall_at) stall_cnt = 5;
      awready = ($urandom_range(0, 3) != 0);
      arready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      bvalid  = (b_pend > 0);
      bresp   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      rvalid  = (rd_q.size() > 0);
      if (rd_q.size() > 0) begin
         rdata = mem_word(rd_q[0][39:8] + 32'(r_beat * 8));
         rlast = (r_beat == int'(rd_q[0][7:0]));
      end else begin
         rdata = 64'd0;
         rlast = 1'b0;
      end
      s_axis_tvalid = (src_q.size() > 0);
      if (src_q.size() > 0) {s_axis_tdata, s_axis_tstrb} = src_q[0];
      m_axis_tready = (stall_cnt == 0);
   end

   // Reference burst split: clip each burst at the next 16-beat (128-byte) boundary.
   task automatic push_expect(input logic [31:0] addr, input logic [31:0] beats, input logic rnw);
      logic [31:0] a, rem, idx, room, len;
      logic [63:0] d;
      logic [7:0]  s;
      a = addr;
      rem = beats;
      while (rem != 32'd0) begin
         idx  = (a >> 3) & 32'd15;
         room = 32'd16 - idx;
         len  = (rem < room) ? rem : room;
         if (rnw) exp_aw_q.push_back({a, 8'(len - 32'd1), 3'd3, 2'b01});
         else     exp_ar_q.push_back({a, 8'(len - 32'd1), 3'd3, 2'b01});
         for (int i = 0; i < int'(len); i++) begin
            if (rnw) begin
               d = {$urandom, $urandom};
               s = 8'($urandom);
               src_q.push_back({d, s});
               exp_w_q.push_back({d, s, 1'(i == int'(len) - 1)});
            end else begin
               exp_m_q.push_back({mem_word(a + 32'(i * 8)), 1'((rem == len) && (i == int'(len) - 1))});
            end
         end
         a   = a + (len << 3);
         rem = rem - len;
      end
   endtask

   task automatic run_cmd(input logic [31:0] addr, input logic [31:0] beats, input logic rnw, input string tag);
      logic ok;
      push_expect(addr, beats, rnw);
      s_aaddr  = addr;
      s_abeats = beats;
      s_arnw   = rnw;
      s_avalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge aclk);
         ok = s_aready;
         @(posedge aclk);
         #1;
      end
      s_avalid = 1'b0;
      check_eq({tag, "_accept"}, ok, 1'b1);
   endtask

   task automatic wait_idle(input string tag);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge aclk);
         done = (exp_aw_q.size() == 0) && (exp_ar_q.size() == 0) && (exp_w_q.size() == 0) &&
                (exp_m_q.size() == 0) && (rd_q.size() == 0) && (b_pend == 0) && s_aready;
      end
      check_eq({tag, "_done"}, done, 1'b1);
      if (!done) begin
         exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete(); exp_m_q.delete(); src_q.delete();
      end
      @(posedge aclk);
      #1;
   endtask

   initial begin
      int a0, r0, b0;
      logic seen;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check_eq("reset_outputs", {s_aready, awvalid, arvalid, wvalid, s_axis_tready, wlast, bready, rready,
                                 m_axis_tvalid, m_axis_tlast, resp_error}, 11'd0);
      @(posedge aclk);
      #1;
      resetn = 1'b1;
      @(negedge aclk);
      check_eq("aready_after_reset", s_aready, 1'b1);
      @(posedge aclk);
      #1;

      // Single 8-beat write; s_aready must be back the cycle after B.
      a0 = aw_cnt; b0 = b_cnt;
      run_cmd(32'h0000_1000, 32'd8, 1'b1, "wr8");
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
         @(negedge aclk);
         if (b_cnt != b0) begin
            seen = 1'b1;
            check_eq("wr8_aready_after_b", s_aready, 1'b1);
         end
      end
      check_eq("wr8_b_seen", seen, 1'b1);
      @(posedge aclk);
      #1;
      wait_idle("wr8");
      check_eq("wr8_aw_count", 32'(aw_cnt - a0), 32'd1);

      a0 = aw_cnt;
      run_cmd(32'h0000_0000, 32'd40, 1'b1, "wr40");
      wait_idle("wr40");
      check_eq("wr40_aw_count", 32'(aw_cnt - a0), 32'd3);

      r0 = ar_cnt;
      run_cmd(32'h0000_0040, 32'd20, 1'b0, "rd20");
      wait_idle("rd20");
      check_eq("rd20_ar_count", 32'(ar_cnt - r0), 32'd2);

      // Sink stalls five cycles in the middle of the first burst.
      stall_at = m_cnt + 4;
      run_cmd(32'h0000_0300, 32'd12, 1'b0, "rd_stall");
      wait_idle("rd_stall");
      stall_at = -1;

      // Burst crossing the top of the address space wraps to zero.
      run_cmd(32'hFFFF_FFF0, 32'd3, 1'b0, "rd_wrap");
      wait_idle("rd_wrap");
      run_cmd(32'h0000_0078, 32'd5, 1'b1, "wr_edge");
      wait_idle("wr_edge");

      check_eq("resp_error_clean", resp_error, 1'b0);
      a0 = aw_cnt;
      err_burst = b_cnt;
      run_cmd(32'h0000_2000, 32'd20, 1'b1, "wr_err");
      wait_idle("wr_err");
      err_burst = -1;
      check_eq("wr_err_aw_count", 32'(aw_cnt - a0), 32'd2);
      check_eq("resp_error_set", resp_error, 1'b1);

      a0 = aw_cnt; r0 = ar_cnt;
      run_cmd(32'h0000_0500, 32'd0, 1'b1, "zero");
      for (int c = 0; c < 4; c++) begin
         @(negedge aclk);
         check_eq("zero_aready", {s_aready, awvalid, arvalid}, 3'b100);
      end
      @(posedge aclk);
      #1;
      check_eq("zero_no_traffic", {32'(aw_cnt - a0), 32'(ar_cnt - r0)}, 64'd0);
      check_eq("resp_error_sticky", resp_error, 1'b1);

      // 16-bit sub-pixel instance: one beat, strobes 0b0101 per sub-pixel.
      w16_avalid = 1'b1;
      @(posedge aclk);
      #1;
      w16_avalid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge aclk);
         if (w16_awvalid) check_eq("w16_awsize", {w16_awlen, w16_awsize}, {8'd0, 3'd4});
         if (w16_wvalid) begin
            seen = 1'b1;
            check_eq("w16_wstrb", {w16_wstrb, w16_wlast}, {16'h0033, 1'b1});
         end
      end
      check_eq("w16_beat_seen", seen, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
